// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package riscv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries with a flush input; DEPTH must be a power of two.
module fetch_queue
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     pop_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     storage [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) storage[wr_ptr] <= push_data;
  end

  assign pop_data = storage[rd_ptr];
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);

  // Upstream credit accounting makes both of these unreachable.
  always @(posedge clk) begin
    if (!rst && !clear) begin
      assert (!(pop && empty));
      assert (!(push && full));
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, response queue, decode handshake.
// Optional FETCH_BYPASS_EN forwards a response straight to decode when the queue is empty.
module fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             fetch_stall,
  output logic             dec_valid,
  output logic [WIDTH-1:0] dec_instr,
  output logic [WIDTH-1:0] dec_pc,
  input  logic             dec_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] fetch_pc_p0;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] q_count;
  logic             q_full, q_empty, pcf_full, pcf_empty;
  logic             req_accept, rsp_keep, q_push, q_pop;
  fetch_entry_t     q_head, q_wdata, pcf_head, pcf_wdata, dec_entry;
  logic             unused_bits;

  // Requests in flight plus queued entries never exceed DEPTH, so responses always fit.
  assign imem_req_valid = !rst && !fetch_stall && !redirect_valid &&
                          (({1'b0, q_count} + {1'b0, outstanding}) < (CNT_W + 1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_p0;
  assign req_accept     = imem_req_valid && imem_req_ready;
  assign rsp_keep       = !rst && imem_rsp_valid && (drop_cnt == '0) && !redirect_valid;

  assign pcf_wdata = '{instr: '0, pc: fetch_pc_p0};
  assign q_wdata   = '{instr: imem_rsp_data, pc: pcf_head.pc};

  // The pc FIFO occupancy is exactly the number of accepted, unanswered requests.
  fetch_queue #(.DEPTH(DEPTH)) u_pc_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (req_accept),
    .push_data (pcf_wdata),
    .pop       (imem_rsp_valid),
    .pop_data  (pcf_head),
    .full      (pcf_full),
    .empty     (pcf_empty),
    .count     (outstanding)
  );

  fetch_queue #(.DEPTH(DEPTH)) u_instr_q (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (q_push),
    .push_data (q_wdata),
    .pop       (q_pop),
    .pop_data  (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

`ifdef FETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = q_empty && rsp_keep;
  assign q_push     = rsp_keep && !(bypass_hit && dec_ready);
  assign dec_valid  = !q_empty || bypass_hit;
  assign dec_entry  = q_empty ? q_wdata : q_head;
`else
  assign q_push     = rsp_keep;
  assign dec_valid  = !q_empty;
  assign dec_entry  = q_head;
`endif

  assign q_pop     = !q_empty && dec_ready;
  assign dec_instr = dec_valid ? dec_entry.instr : NOP_INSTR;
  assign dec_pc    = dec_valid ? dec_entry.pc : '0;

  assign unused_bits = ^{q_full, pcf_full, pcf_empty, pcf_head.instr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_p0 <= RESET_PC;
      drop_cnt    <= '0;
    end else if (redirect_valid) begin
      fetch_pc_p0 <= {redirect_pc[WIDTH-1:2], 2'b00};
      drop_cnt    <= outstanding - CNT_W'(imem_rsp_valid);
    end else begin
      if (req_accept) fetch_pc_p0 <= fetch_pc_p0 + WIDTH'(4);
      if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed fetch streams against an in-order variable-latency memory.
`timescale 1ns/1ps
module tb_fetch_unit;
  import riscv_fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid, fetch_stall, dec_valid, dec_ready;
  logic [31:0] redirect_pc, dec_instr, dec_pc;
  logic        w_req_valid, w_dec_valid;
  logic [31:0] w_req_addr, w_dec_instr, w_dec_pc;

  int vectors = 0;
  int miscompares = 0;
  int mem_lat = 1;
  int cyc = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t        pend[$];
  fetch_entry_t expq[$];

  fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_stall(fetch_stall),
    .dec_valid(dec_valid), .dec_instr(dec_instr), .dec_pc(dec_pc), .dec_ready(dec_ready)
  );

  // Lock-stepped twin with a reset PC at the top of the address space.
  fetch_unit #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_stall(fetch_stall),
    .dec_valid(w_dec_valid), .dec_instr(w_dec_instr), .dec_pc(w_dec_pc), .dec_ready(dec_ready)
  );

  initial forever #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0003;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    fetch_entry_t e;
    e.instr = mem_word(pc);
    e.pc    = pc;
    expq.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (3) tick();
    check("drain_left", expq.size(), 0);
  endtask

  // Memory: accepts sampled mid-cycle, answered in order mem_lat cycles later.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) pend.delete();
      else if (imem_req_valid && imem_req_ready) pend.push_back('{imem_req_addr, cyc + mem_lat});
      @(posedge clk);
      #1;
      cyc++;
      if (!rst && pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
    end
  end

  // Monitor: every decode consumption must match the scoreboard head.
  initial forever begin
    @(negedge clk);
    if (dec_valid && dec_ready) begin
      if (expq.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL dec_unexpected: got pc %h, expected no entry", dec_pc);
      end else begin
        fetch_entry_t e;
        e = expq.pop_front();
        check("dec_pc", dec_pc, e.pc);
        check("dec_instr", dec_instr, e.instr);
      end
    end else if (!dec_valid) begin
      check("idle_instr", dec_instr, NOP_INSTR);
      check("idle_pc", dec_pc, 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected summary");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    imem_req_ready = 1'b1;
    dec_ready = 1'b1;
    fetch_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    // Reset values and sustained stream from reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_dec_valid", dec_valid, 0);
    check("rst_wrap_addr", w_req_addr, 32'hFFFF_FFFC);
    for (int k = 0; k < 8; k++) push_exp(32'(k * 4));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i < 4) begin
        check("stream_req_valid", imem_req_valid, 1);
        check("stream_req_addr", imem_req_addr, 32'(i * 4));
      end
      if (i == 0) check("wrap_first", w_req_addr, 32'hFFFF_FFFC);
      if (i == 1) check("wrap_second", w_req_addr, 32'h0000_0000);
      check("stream_dec_valid", dec_valid, (i >= 2 - BYP && i <= 9 - BYP) ? 1 : 0);
      tick();
      if (i == 7) fetch_stall = 1'b1;
    end
    drain(30);

    // Backpressure: credits stop requests at four.
    dec_ready = 1'b0;
    fetch_stall = 1'b0;
    for (int k = 0; k < 6; k++) push_exp(32'h20 + 32'(k * 4));
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (i < 4) check("bp_req_addr", imem_req_addr, 32'h20 + 32'(i * 4));
      if (i >= 4 && i <= 10) check("bp_credit_stop", imem_req_valid, 0);
      if (i == 11) begin
        check("bp_resume_valid", imem_req_valid, 1);
        check("bp_resume_addr", imem_req_addr, 32'h30);
      end
      tick();
      if (i == 9) dec_ready = 1'b1;
      if (i == 12) fetch_stall = 1'b1;
    end
    drain(30);

    // Redirect with two requests outstanding on a 3-cycle memory.
    mem_lat = 3;
    fetch_stall = 1'b0;
    push_exp(32'h40);
    push_exp(32'h44);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 0) check("redir_pre_addr0", imem_req_addr, 32'h38);
      if (i == 1) check("redir_pre_addr1", imem_req_addr, 32'h3C);
      if (i == 2) check("redir_no_req", imem_req_valid, 0);
      if (i == 3) begin
        check("redir_target_valid", imem_req_valid, 1);
        check("redir_target_addr", imem_req_addr, 32'h40);
      end
      if (i >= 3 && i <= 5) check("redir_stale_dropped", dec_valid, 0);
      if (i == 6) check("redir_first_valid", dec_valid, BYP);
      if (i == 7) check("redir_valid_on", dec_valid, 1);
      tick();
      if (i == 1) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h43;
      end
      if (i == 2) redirect_valid = 1'b0;
      if (i == 4) fetch_stall = 1'b1;
    end
    drain(30);

    // Redirect coinciding with a response on a 2-cycle memory.
    mem_lat = 2;
    fetch_stall = 1'b0;
    push_exp(32'h80);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 2) check("redir_rsp_no_req", imem_req_valid, 0);
      if (i == 3) begin
        check("redir_rsp_target", imem_req_addr, 32'h80);
        check("redir_rsp_drop", 32'(u_dut.drop_cnt), 1);
      end
      if (i == 3 || i == 4) check("redir_rsp_dropped", dec_valid, 0);
      if (i == 5) check("redir_rsp_first", dec_valid, BYP);
      tick();
      if (i == 1) begin
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
      end
      if (i == 2) redirect_valid = 1'b0;
      if (i == 3) fetch_stall = 1'b1;
    end
    drain(30);

    // Asynchronous reset between edges in the middle of a stream.
    mem_lat = 1;
    fetch_stall = 1'b0;
    push_exp(32'h84);
    if (BYP == 1) push_exp(32'h88);
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    check("arst_dec_valid", dec_valid, 0);
    check("arst_req_valid", imem_req_valid, 0);
    check("arst_req_addr", imem_req_addr, 32'h0);
    check("arst_dec_pc", dec_pc, 32'h0);
    push_exp(32'h0);
    @(negedge clk);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("restart_valid", imem_req_valid, 1);
    check("restart_addr", imem_req_addr, 32'h0);
    tick();
    fetch_stall = 1'b1;
    drain(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
